command_encoder: RTL and testbench

COMMAND_ENCODER -- requirements
Module: command_encoder

---
 rtl/command_encoder_pkg.sv | 70 +++++++
 rtl/command_encoder_if.sv | 31 +++
 rtl/command_encoder.sv | 164 ++++++++++++++++
 tb/tb_command_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/command_encoder_pkg.sv
// Shared rasterizer definitions used by the command encoder and the matching
// decoder. It holds the command codes, the CLEAR byte, the stream byte layout
// ([7] en, [6:5] cmd, [4:0] param) and the helpers that pack stream bytes.
package command_encoder_pkg;

    localparam logic [1:0] CMD_ILLEGAL = 2'b00;
    localparam logic [1:0] CMD_PIXEL   = 2'b01;
    localparam logic [1:0] CMD_LINE    = 2'b10;
    localparam logic [1:0] CMD_RECT    = 2'b11;

    localparam logic [7:0] CLEAR_BYTE  = 8'hBF;

    localparam int EN_BIT    = 7;
    localparam int CMD_MSB   = 6;
    localparam int CMD_LSB   = 5;
    localparam int PARAM_MSB = 4;
    localparam int PARAM_LSB = 0;

    localparam int COORD_W   = 3;

    typedef logic [COORD_W-1:0] coord_t;

    // Snapshot of one request, captured when it is accepted.
    typedef struct packed {
        logic       clear;
        logic [1:0] cmd;
        coord_t     x1;
        coord_t     y1;
        coord_t     x2;
        coord_t     y2;
        coord_t     width;
        coord_t     height;
    } cmd_fields_t;

    // Head byte: enable set, command code, first coordinate.
    function automatic logic [7:0] make_head(input logic [1:0] cmd, input coord_t x1);
        logic [7:0] b;
        b = 8'h00;
        b[EN_BIT] = 1'b1;
        b[CMD_MSB:CMD_LSB] = cmd;
        b[PARAM_MSB:PARAM_LSB] = {2'b00, x1};
        return b;
    endfunction

    // Parameter byte: enable set, command field zero, value.
    function automatic logic [7:0] make_param(input coord_t value);
        logic [7:0] b;
        b = 8'h00;
        b[EN_BIT] = 1'b1;
        b[PARAM_MSB:PARAM_LSB] = {2'b00, value};
        return b;
    endfunction

    // Number of parameter bytes that follow the head byte.
    function automatic logic [1:0] param_count(input logic clear, input logic [1:0] cmd);
        logic [1:0] n;
        if (clear) begin
            n = 2'd0;
        end else begin
            case (cmd)
                CMD_PIXEL: n = 2'd1;
                CMD_LINE:  n = 2'd3;
                CMD_RECT:  n = 2'd3;
                default:   n = 2'd0;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/command_encoder_if.sv
// Request/stream bundle of the command encoder.
//   master : requester side (drives in_*, observes ready and the byte stream)
//   slave  : encoder side
interface command_encoder_if;
    import command_encoder_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic       in_clear;
    logic [1:0] in_cmd;
    coord_t     in_x1;
    coord_t     in_y1;
    coord_t     in_x2;
    coord_t     in_y2;
    coord_t     in_width;
    coord_t     in_height;
    logic [7:0] tx_byte;
    logic       tx_last;
    logic       busy;
    logic       err;

    modport master (
        output in_valid, in_clear, in_cmd, in_x1, in_y1, in_x2, in_y2, in_width, in_height,
        input  in_ready, tx_byte, tx_last, busy, err
    );

    modport slave (
        input  in_valid, in_clear, in_cmd, in_x1, in_y1, in_x2, in_y2, in_width, in_height,
        output in_ready, tx_byte, tx_last, busy, err
    );
endinterface

// File: rtl/command_encoder.sv
// Command encoder: turns one drawing request into a serial byte stream
// (head byte, parameter bytes, then GAP_CYCLES idle 0x00 bytes).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    command_encoder_if.slave: in_valid/in_ready handshake, in_clear,
//          in_cmd, coordinates; tx_byte, tx_last, busy, err (all registered)
// Parameter GAP_CYCLES (1..7): idle bytes appended after every command.
module command_encoder
    import command_encoder_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input logic               clk,
    input logic               rst_n,
    command_encoder_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HEAD  = 2'd1;
    localparam logic [1:0] ST_PARAM = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

    logic [1:0]  state_r, state_s;
    logic [1:0]  param_idx_r, param_idx_s;
    logic [1:0]  param_inc_s;
    logic [1:0]  param_cnt_s;
    logic [2:0]  gap_cnt_r, gap_cnt_s;
    cmd_fields_t fields_r;
    logic [7:0]  tx_byte_r, tx_byte_s;
    logic        tx_last_r, tx_last_s;
    logic        busy_r;
    logic        err_r;
    logic        in_ready_r;
    logic        accept_s;
    logic        illegal_s;

    // Parameter value for a given slot of the latched command.
    function automatic coord_t select_param(input cmd_fields_t f, input logic [1:0] idx);
        coord_t v;
        case (idx)
            2'd0:    v = f.y1;
            2'd1:    v = (f.cmd == CMD_RECT) ? f.width  : f.x2;
            2'd2:    v = (f.cmd == CMD_RECT) ? f.height : f.y2;
            default: v = f.x1; // slot 3 never occurs inside a command
        endcase
        return v;
    endfunction

    assign accept_s    = bus.in_valid && in_ready_r;
    assign illegal_s   = !bus.in_clear && (bus.in_cmd == CMD_ILLEGAL);
    assign param_cnt_s = param_count(fields_r.clear, fields_r.cmd);
    assign param_inc_s = param_idx_r + 2'd1;

    // Next state and the byte that the output register loads on the next edge.
    always_comb begin
        state_s     = state_r;
        param_idx_s = param_idx_r;
        gap_cnt_s   = gap_cnt_r;
        tx_byte_s   = 8'h00;
        tx_last_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && bus.in_clear) begin
                    state_s     = ST_HEAD;
                    param_idx_s = 2'd0;
                    gap_cnt_s   = 3'd0;
                    tx_byte_s   = CLEAR_BYTE;
                    tx_last_s   = 1'b1;
                end else if (accept_s && !illegal_s) begin
                    state_s     = ST_HEAD;
                    param_idx_s = 2'd0;
                    gap_cnt_s   = 3'd0;
                    tx_byte_s   = make_head(bus.in_cmd, bus.in_x1);
                    tx_last_s   = 1'b0;
                end else if (accept_s) begin
                    // Illegal request: consumed, flagged, nothing sent.
                    state_s     = ST_IDLE;
                    param_idx_s = 2'd0;
                    gap_cnt_s   = 3'd0;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_HEAD: begin
                if (param_cnt_s != 2'd0) begin
                    state_s     = ST_PARAM;
                    param_idx_s = 2'd0;
                    tx_byte_s   = make_param(select_param(fields_r, 2'd0));
                    tx_last_s   = (param_cnt_s == 2'd1);
                end else begin
                    state_s     = ST_GAP;
                    gap_cnt_s   = 3'd0;
                end
            end
            ST_PARAM: begin
                if (param_inc_s < param_cnt_s) begin
                    param_idx_s = param_inc_s;
                    tx_byte_s   = make_param(select_param(fields_r, param_inc_s));
                    tx_last_s   = (param_inc_s == (param_cnt_s - 2'd1));
                end else begin
                    state_s     = ST_GAP;
                    gap_cnt_s   = 3'd0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s   = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + 3'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            param_idx_r <= 2'd0;
            gap_cnt_r   <= 3'd0;
            fields_r    <= '0;
            tx_byte_r   <= 8'h00;
            tx_last_r   <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            param_idx_r <= param_idx_s;
            gap_cnt_r   <= gap_cnt_s;
            tx_byte_r   <= tx_byte_s;
            tx_last_r   <= tx_last_s;
            busy_r      <= (state_s != ST_IDLE);
            err_r       <= accept_s && illegal_s;
            // Ready tracks the state being entered so it is high exactly in IDLE.
            in_ready_r  <= (state_s == ST_IDLE);
            if (accept_s) begin
                fields_r <= '{clear:  bus.in_clear,
                              cmd:    bus.in_cmd,
                              x1:     bus.in_x1,
                              y1:     bus.in_y1,
                              x2:     bus.in_x2,
                              y2:     bus.in_y2,
                              width:  bus.in_width,
                              height: bus.in_height};
            end else begin
                fields_r <= fields_r;
            end
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.tx_byte  = tx_byte_r;
    assign bus.tx_last  = tx_last_r;
    assign bus.busy     = busy_r;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_command_encoder.sv
// Bench for command_encoder (GAP_CYCLES = 2): directed encodings, illegal
// request, back-to-back with in_valid held, reset mid-command, then random
// requests checked cycle by cycle against a byte-list reference model.
module tb_command_encoder;

    localparam int GAP = 2;

    typedef struct {
        int clear;
        int cmd;
        int x1, y1, x2, y2, w, h;
    } req_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   exp_b [0:3];
    int   exp_n;
    int   obs_b [0:3];
    int   obs_n;

    command_encoder_if bus ();

    command_encoder #(.GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the byte list a request must produce, by plain arithmetic.
    task automatic model_bytes(input req_t r);
        if (r.clear != 0) begin
            exp_b[0] = 191;
            exp_n = 1;
        end else if (r.cmd == 0) begin
            exp_n = 0;
        end else begin
            exp_b[0] = 128 + 32 * r.cmd + r.x1;
            exp_b[1] = 128 + r.y1;
            if (r.cmd == 2) begin
                exp_b[2] = 128 + r.x2;
                exp_b[3] = 128 + r.y2;
                exp_n = 4;
            end else if (r.cmd == 3) begin
                exp_b[2] = 128 + r.w;
                exp_b[3] = 128 + r.h;
                exp_n = 4;
            end else begin
                exp_n = 2;
            end
        end
    endtask

    task automatic drive(input req_t r, input logic v);
        bus.in_valid  = v;
        bus.in_clear  = 1'(r.clear);
        bus.in_cmd    = 2'(r.cmd);
        bus.in_x1     = 3'(r.x1);
        bus.in_y1     = 3'(r.y1);
        bus.in_x2     = 3'(r.x2);
        bus.in_y2     = 3'(r.y2);
        bus.in_width  = 3'(r.w);
        bus.in_height = 3'(r.h);
    endtask

    task automatic junk();
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_clear  = 1'($urandom_range(0, 1));
        bus.in_cmd    = 2'($urandom_range(0, 3));
        bus.in_x1     = 3'($urandom_range(0, 7));
        bus.in_y1     = 3'($urandom_range(0, 7));
        bus.in_x2     = 3'($urandom_range(0, 7));
        bus.in_y2     = 3'($urandom_range(0, 7));
        bus.in_width  = 3'($urandom_range(0, 7));
        bus.in_height = 3'($urandom_range(0, 7));
    endtask

    function automatic req_t mk(input int clear, input int cmd, input int x1, input int y1,
                                input int x2, input int y2, input int w, input int h);
        req_t r;
        r.clear = clear; r.cmd = cmd; r.x1 = x1; r.y1 = y1;
        r.x2 = x2; r.y2 = y2; r.w = w; r.h = h;
        return r;
    endfunction

    function automatic req_t rand_req();
        return mk(($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    endfunction

    // Called at a negedge with the encoder idle; returns at the negedge of
    // the idle cycle that follows the command (or right after an illegal one).
    task automatic run_req(input req_t r, input bit hold, input req_t nxt);
        int n;
        drive(r, 1'b1);
        check("ready_idle", 32'(bus.in_ready), 32'd1);
        model_bytes(r);
        n = exp_n;
        obs_n = 0;
        @(posedge clk);
        @(negedge clk);
        if (hold) drive(nxt, 1'b1);
        else if (n == 0) bus.in_valid = 1'b0;
        else junk();
        if (n == 0) begin
            check("err_pulse", 32'(bus.err), 32'd1);
            check("err_byte", 32'(bus.tx_byte), 32'd0);
            check("err_busy", 32'(bus.busy), 32'd0);
            check("err_ready", 32'(bus.in_ready), 32'd1);
        end else begin
            for (int k = 0; k < n + GAP; k++) begin
                if (k < n) begin
                    check("byte", 32'(bus.tx_byte), 32'(exp_b[k]));
                    check("last", 32'(bus.tx_last), (k == n - 1) ? 32'd1 : 32'd0);
                    obs_b[obs_n] = int'(bus.tx_byte);
                    obs_n++;
                end else begin
                    check("gap_byte", 32'(bus.tx_byte), 32'd0);
                    check("gap_last", 32'(bus.tx_last), 32'd0);
                end
                check("busy", 32'(bus.busy), 32'd1);
                check("ready_busy", 32'(bus.in_ready), 32'd0);
                check("no_err", 32'(bus.err), 32'd0);
                @(negedge clk);
                if (!hold && k < n + GAP - 1) junk();
                else if (!hold) bus.in_valid = 1'b0;
            end
            check("idle_byte", 32'(bus.tx_byte), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_err", 32'(bus.err), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t none, cur, nxt, pix, line;
        bit   hold;
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        none  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        drive(none, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_byte", 32'(bus.tx_byte), 32'd0);
        check("rst_last", 32'(bus.tx_last), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Directed encodings.
        pix = mk(0, 1, 3, 5, 0, 0, 0, 0);
        run_req(pix, 1'b0, none);
        check("pix_b0", 32'(obs_b[0]), 32'h0A3);
        check("pix_b1", 32'(obs_b[1]), 32'h085);
        line = mk(0, 2, 1, 2, 6, 7, 0, 0);
        run_req(line, 1'b0, none);
        check("line_b0", 32'(obs_b[0]), 32'h0C1);
        check("line_b3", 32'(obs_b[3]), 32'h087);
        // Loopback decode of the captured line stream.
        check("dec_cmd", 32'((obs_b[0] / 32) % 4), 32'd2);
        check("dec_x1", 32'(obs_b[0] % 32), 32'd1);
        check("dec_y1", 32'(obs_b[1] % 32), 32'd2);
        check("dec_x2", 32'(obs_b[2] % 32), 32'd6);
        check("dec_y2", 32'(obs_b[3] % 32), 32'd7);
        run_req(mk(0, 3, 2, 3, 0, 0, 4, 5), 1'b0, none);
        check("rect_b0", 32'(obs_b[0]), 32'h0E2);
        check("rect_b3", 32'(obs_b[3]), 32'h085);
        run_req(mk(1, 2, 7, 7, 7, 7, 7, 7), 1'b0, none);
        check("clear_b0", 32'(obs_b[0]), 32'h0BF);
        check("clear_len", 32'(obs_n), 32'd1);
        run_req(mk(0, 0, 1, 1, 1, 1, 1, 1), 1'b0, none);

        // Back-to-back with in_valid held, next request presented mid-command.
        run_req(pix, 1'b1, line);
        run_req(line, 1'b1, mk(0, 3, 6, 5, 4, 3, 2, 1));
        run_req(mk(0, 3, 6, 5, 4, 3, 2, 1), 1'b0, none);

        // Reset while the third byte of a line is on the wire.
        drive(line, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("third_byte", 32'(bus.tx_byte), 32'h086);
        rst_n = 1'b0;
        #1;
        check("rst_mid_byte", 32'(bus.tx_byte), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_last", 32'(bus.tx_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_rel", 32'(bus.in_ready), 32'd1);
        check("rel_byte", 32'(bus.tx_byte), 32'd0);
        run_req(pix, 1'b0, none);
        check("rel_pix_b0", 32'(obs_b[0]), 32'h0A3);

        // Random traffic.
        cur = rand_req();
        for (int i = 0; i < 80; i++) begin
            nxt  = rand_req();
            hold = ($urandom_range(0, 1) == 1);
            run_req(cur, hold, nxt);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
            cur = nxt;
        end

        bus.in_valid = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
